// File: rtl/seq_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   DIGIT_W : bits consumed per clock (one comparator-cell digit)
//   state_e : FSM state type, values pinned to the ST_* encodings
package seq_cmp_pkg;

    localparam int unsigned DIGIT_W = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/seq_cmp_if.sv
// Operand/result handshake bundle for seq_cmp.
//   in_valid/in_ready/a/b      : operand pair handshake
//   out_valid/out_ready/eq/lt/gt : result handshake, flags one-hot while out_valid
//   busy                       : comparator is in RUN or DONE
// slave is the comparator side, master is the producer/consumer side.
interface seq_cmp_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic         eq;
    logic         lt;
    logic         gt;
    logic         busy;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, eq, lt, gt, busy
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, eq, lt, gt, busy
    );
endinterface

// File: rtl/seq_cmp_slice.sv
// 2-bit unsigned comparator cell, purely combinational.
//   x, y        : digits to compare
//   eq, lt, gt  : x == y, x < y, x > y (exactly one is high)
module seq_cmp_slice
    import seq_cmp_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic               eq,
    output logic               lt,
    output logic               gt
);
    assign eq = (x == y);
    assign lt = (x < y);
    assign gt = (x > y);
endmodule

// File: rtl/seq_cmp.sv
// Serial W-bit unsigned magnitude comparator. Captures an operand pair, walks it
// MSB-first one 2-bit digit per clock through seq_cmp_slice, stops at the first
// unequal digit and holds a one-hot eq/lt/gt result until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_cmp_if slave (operand handshake, result handshake, busy)
// W must be even and at least 2.
module seq_cmp
    import seq_cmp_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_cmp_if.slave bus
);
    localparam int unsigned N    = W / DIGIT_W;
    localparam int unsigned CntW = $clog2(N + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;
    logic            gt_q, gt_d;

    logic            dig_eq;
    logic            dig_lt;
    logic            dig_gt;

    // Only the top digit of each shift register is ever examined.
    seq_cmp_slice u_slice (
        .x  (sa_q[W-1 -: DIGIT_W]),
        .y  (sb_q[W-1 -: DIGIT_W]),
        .eq (dig_eq),
        .lt (dig_lt),
        .gt (dig_gt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;

        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    cnt_d   = CntW'(N);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!dig_eq) begin
                    // Early exit: the first unequal digit decides the magnitude.
                    lt_d    = dig_lt;
                    gt_d    = dig_gt;
                    state_d = StDone;
                end else if (cnt_q == CntW'(1)) begin
                    eq_d    = 1'b1;
                    state_d = StDone;
                end else begin
                    sa_d  = sa_q << DIGIT_W;
                    sb_d  = sb_q << DIGIT_W;
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
        end
    end

    // Flags are zero outside DONE because they are only set on entry to DONE
    // and cleared on exit, so they can drive the outputs directly.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.eq        = eq_q;
    assign bus.lt        = lt_q;
    assign bus.gt        = gt_q;
endmodule
